// File: rtl/fm_pkg.sv
// Shared definitions for the frequency-meter result path.
// Holds the sequencer state encoding, parameter defaults and result RAM address map.
// The CPU-side address decoder uses the same address helpers.
package fm_pkg;

   localparam int F_INPUTS_COUNT   = 24;
   localparam int FM_DEF_CNT_W     = 24;
   localparam int FM_DEF_REF_W     = 30;
   localparam int FM_DEF_ADDR_W    = 6;
   localparam int FM_WORDS_PER_CH  = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_PER = 2'd1,
      ST_WR_REF = 2'd2,
      ST_ACK    = 2'd3
   } fm_state_t;

   // Word address of the period count of channel c
   function automatic int unsigned per_addr(input int unsigned c);
      return c * FM_WORDS_PER_CH;
   endfunction

   // Word address of the reference count of channel c
   function automatic int unsigned ref_addr(input int unsigned c);
      return c * FM_WORDS_PER_CH + 1;
   endfunction

endpackage

// File: rtl/fm_rr_arbiter.sv
// Round-robin picker: first requester at or after last+1 (mod N) wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples the grant only when it can accept it.
module fm_rr_arbiter #(
   parameter int N     = 24,
   parameter int IDX_W = 5
)(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan requesters in rotating order starting just past the last winner
   always_comb begin
      int unsigned pos;
      pos = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         pos = (32'(last) + 32'd1 + 32'(i)) % 32'(N);
         if (!any && req[pos[IDX_W-1:0]]) begin
            any                  = 1'b1;
            gnt[pos[IDX_W-1:0]]  = 1'b1;
            idx                  = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fm_result_sequencer.sv
// Serialises completed channel measurements into the result RAM and raises sticky IRQ flags.
// Latency: grant edge E, RAM writes in E+1/E+2, ack pulse in E+3, idle again at E+4.
// Backpressure: channels hold ready and data stable until acked; ungranted channels simply wait.
module fm_result_sequencer
   import fm_pkg::*;
#(
   parameter int CHANNELS = F_INPUTS_COUNT,
   parameter int CNT_W    = FM_DEF_CNT_W,
   parameter int REF_W    = FM_DEF_REF_W,
   parameter int ADDR_W   = FM_DEF_ADDR_W
)(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [CHANNELS-1:0]       ch_ready_i,
   input  logic [CHANNELS*CNT_W-1:0] ch_periods_i,
   input  logic [CHANNELS*REF_W-1:0] ch_ref_i,
   input  logic [CHANNELS-1:0]       ch_enable_i,
   output logic [CHANNELS-1:0]       ch_ack_o,
   output logic                      mem_we_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [31:0]               mem_data_o,
   output logic [CHANNELS-1:0]       irq_pending_o,
   input  logic [CHANNELS-1:0]       irq_clr_i,
   output logic                      irq_o,
   output logic                      busy_o
);

   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(CHANNELS - 1);

   fm_state_t           state;
   logic [IDX_W-1:0]    last;
   logic [IDX_W-1:0]    g;
   logic [REF_W-1:0]    ref_q;
   logic [CHANNELS-1:0] eligible;
   logic [CHANNELS-1:0] gnt_oh;
   logic [IDX_W-1:0]    gnt_idx;
   logic                gnt_any;
   logic [CHANNELS-1:0] g_oh;
   logic [CHANNELS-1:0] irq_set;
   logic [CNT_W-1:0]    per_sel;
   logic [REF_W-1:0]    ref_sel;

   assign eligible = ch_ready_i & ch_enable_i;
   assign g_oh     = CHANNELS'(1) << g;
   assign irq_o    = |irq_pending_o;

   fm_rr_arbiter #(
      .N     (CHANNELS),
      .IDX_W (IDX_W)
   ) u_arb (
      .req  (eligible),
      .last (last),
      .gnt  (gnt_oh),
      .idx  (gnt_idx),
      .any  (gnt_any)
   );

   // AND-OR select of the granted channel's counts (grant is one-hot)
   always_comb begin
      per_sel = '0;
      ref_sel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (gnt_oh[c]) begin
            per_sel = per_sel | ch_periods_i[c*CNT_W +: CNT_W];
            ref_sel = ref_sel | ch_ref_i[c*REF_W +: REF_W];
         end
      end
   end

   // Service FSM: grant, write period word, write reference word, ack
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= ST_IDLE;
         last       <= LAST_RST;
         g          <= '0;
         ref_q      <= '0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         ch_ack_o   <= '0;
         busy_o     <= 1'b0;
      end else begin
         mem_we_o <= 1'b0;
         ch_ack_o <= '0;
         case (state)
            ST_IDLE: begin
               if (gnt_any) begin
                  // The period word goes out straight from the grant-edge sample
                  g          <= gnt_idx;
                  ref_q      <= ref_sel;
                  mem_we_o   <= 1'b1;
                  mem_addr_o <= ADDR_W'(per_addr(32'(gnt_idx)));
                  mem_data_o <= 32'(per_sel);
                  busy_o     <= 1'b1;
                  state      <= ST_WR_PER;
               end
            end
            ST_WR_PER: begin
               mem_we_o   <= 1'b1;
               mem_addr_o <= ADDR_W'(ref_addr(32'(g)));
               mem_data_o <= 32'(ref_q);
               state      <= ST_WR_REF;
            end
            ST_WR_REF: begin
               ch_ack_o <= g_oh;
               state    <= ST_ACK;
            end
            default: begin
               last   <= g;
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   // Flag is raised with the ack and held through the ack cycle so a coincident clear loses
   always_comb begin
      irq_set = '0;
      if (state == ST_WR_REF || state == ST_ACK)
         irq_set = g_oh;
   end

   // Sticky per-channel interrupt flags, write-1-to-clear, set has priority
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         irq_pending_o <= '0;
      else
         irq_pending_o <= (irq_pending_o & ~irq_clr_i) | irq_set;
   end

endmodule

// File: tb/tb_fm_result_sequencer.sv
// Directed bench for fm_result_sequencer with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// Channels drop ready on their ack unless a test holds them high.
module tb_fm_result_sequencer;

   localparam int CH    = 24;
   localparam int CNT_W = 24;
   localparam int REF_W = 30;
   localparam int ADDR_W = 6;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic [CH-1:0]          ch_ready;
   logic [CH*CNT_W-1:0]    ch_periods;
   logic [CH*REF_W-1:0]    ch_ref;
   logic [CH-1:0]          ch_enable;
   logic [CH-1:0]          ch_ack;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [31:0]            mem_data;
   logic [CH-1:0]          irq_pending;
   logic [CH-1:0]          irq_clr;
   logic                   irq;
   logic                   busy;

   int total = 0;
   int bad   = 0;
   bit auto_clr = 1'b1;
   int rr_exp[4] = '{0, 3, 23, 0};

   always #5 clk_i = ~clk_i;

   fm_result_sequencer #(
      .CHANNELS (CH),
      .CNT_W    (CNT_W),
      .REF_W    (REF_W),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ch_ready_i    (ch_ready),
      .ch_periods_i  (ch_periods),
      .ch_ref_i      (ch_ref),
      .ch_enable_i   (ch_enable),
      .ch_ack_o      (ch_ack),
      .mem_we_o      (mem_we),
      .mem_addr_o    (mem_addr),
      .mem_data_o    (mem_data),
      .irq_pending_o (irq_pending),
      .irq_clr_i     (irq_clr),
      .irq_o         (irq),
      .busy_o        (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge; a well-behaved channel drops ready on its ack
   task automatic tick();
      @(negedge clk_i);
      if (auto_clr) ch_ready = ch_ready & ~ch_ack;
   endtask

   task automatic clear_irqs();
      irq_clr = '1;
      tick();
      irq_clr = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i      = 1'b0;
      ch_ready   = '0;
      ch_enable  = '1;
      irq_clr    = '0;
      ch_periods = '0;
      ch_ref     = '0;
      for (int c = 0; c < CH; c++) begin
         ch_periods[c*CNT_W +: CNT_W] = CNT_W'(32'h100 + c);
         ch_ref[c*REF_W +: REF_W]     = REF_W'(32'h200 + c);
      end

      // Reset state
      repeat (3) tick();
      chk("rst_we",   mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", mem_data, 0);
      chk("rst_ack",  ch_ack, 0);
      chk("rst_irqp", irq_pending, 0);
      chk("rst_irq",  irq, 0);
      chk("rst_busy", busy, 0);
      rst_i = 1'b1;

      // Round robin across channels 0, 3, 23 held ready
      auto_clr = 1'b0;
      ch_ready = (CH'(1) << 0) | (CH'(1) << 3) | (CH'(1) << 23);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_we1",   mem_we, 1);
         chk("rr_addr1", mem_addr, 64'(2 * rr_exp[k]));
         chk("rr_data1", mem_data, 64'(32'h100 + rr_exp[k]));
         chk("rr_busy1", busy, 1);
         tick();
         chk("rr_we2",   mem_we, 1);
         chk("rr_addr2", mem_addr, 64'(2 * rr_exp[k] + 1));
         chk("rr_data2", mem_data, 64'(32'h200 + rr_exp[k]));
         tick();
         chk("rr_we3",   mem_we, 0);
         chk("rr_ack",   ch_ack, 64'd1 << rr_exp[k]);
         chk("rr_busy3", busy, 1);
         tick();
         chk("rr_ack4",  ch_ack, 0);
         chk("rr_busy4", busy, 0);
      end
      ch_ready = '0;
      auto_clr = 1'b1;
      chk("rr_irqp", irq_pending, (64'd1 << 0) | (64'd1 << 3) | (64'd1 << 23));
      clear_irqs();
      chk("rr_irqclr", irq_pending, 0);

      // Channel 5 alone; inputs change after the grant edge
      ch_periods[5*CNT_W +: CNT_W] = 24'h123456;
      ch_ref[5*REF_W +: REF_W]     = 30'h2FAF080;
      ch_ready[5] = 1'b1;
      tick();
      chk("c5_we1",   mem_we, 1);
      chk("c5_addr1", mem_addr, 10);
      chk("c5_data1", mem_data, 32'h00123456);
      ch_periods[5*CNT_W +: CNT_W] = '0;
      ch_ref[5*REF_W +: REF_W]     = '0;
      tick();
      chk("c5_we2",   mem_we, 1);
      chk("c5_addr2", mem_addr, 11);
      chk("c5_data2", mem_data, 32'h02FAF080);
      tick();
      chk("c5_ack",   ch_ack, 64'd1 << 5);
      tick();
      chk("c5_irqp",  irq_pending, 64'd1 << 5);
      chk("c5_irq",   irq, 1);
      chk("c5_idle",  mem_we, 0);
      clear_irqs();

      // Channel 7 ready but disabled, then enabled; dropping enable mid-service does not abort
      ch_enable[7] = 1'b0;
      ch_ready[7]  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("dis_we",   mem_we, 0);
         chk("dis_busy", busy, 0);
      end
      ch_enable[7] = 1'b1;
      tick();
      chk("en_we1",   mem_we, 1);
      chk("en_addr1", mem_addr, 14);
      chk("en_data1", mem_data, 32'h107);
      ch_enable[7] = 1'b0;
      tick();
      chk("en_addr2", mem_addr, 15);
      chk("en_data2", mem_data, 32'h207);
      tick();
      chk("en_ack",   ch_ack, 64'd1 << 7);
      tick();
      chk("en_busy",  busy, 0);
      ch_enable = '1;
      clear_irqs();

      // Clear coinciding with the ack of channel 2 loses; a later clear wins
      ch_ready[2] = 1'b1;
      tick();
      tick();
      tick();
      chk("i2_ack", ch_ack, 64'd1 << 2);
      irq_clr[2] = 1'b1;
      tick();
      irq_clr = '0;
      chk("i2_hold", irq_pending, 64'd1 << 2);
      chk("i2_irq1", irq, 1);
      irq_clr[2] = 1'b1;
      tick();
      irq_clr = '0;
      chk("i2_clr",  irq_pending, 0);
      chk("i2_irq0", irq, 0);

      // Reset during the reference write of channel 4, then full re-service
      ch_ready[4] = 1'b1;
      tick();
      chk("r4_addr1", mem_addr, 8);
      tick();
      chk("r4_we2",   mem_we, 1);
      chk("r4_addr2", mem_addr, 9);
      rst_i = 1'b0;
      #1;
      chk("r4_we_rst",   mem_we, 0);
      chk("r4_ack_rst",  ch_ack, 0);
      chk("r4_busy_rst", busy, 0);
      tick();
      chk("r4_noack", ch_ack, 0);
      chk("r4_ready", ch_ready[4], 1);
      rst_i = 1'b1;
      tick();
      chk("r4_we1b",   mem_we, 1);
      chk("r4_addr1b", mem_addr, 8);
      chk("r4_data1b", mem_data, 32'h104);
      tick();
      chk("r4_addr2b", mem_addr, 9);
      chk("r4_data2b", mem_data, 32'h204);
      tick();
      chk("r4_ackb",  ch_ack, 64'd1 << 4);
      tick();
      chk("r4_irqp",  irq_pending, 64'd1 << 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
